// File: rtl/seq_lshift_if.sv
// Handshake and data bundle for the sequential left shifter.
// The master issues start/a/b, and the slave returns busy/done/s/cout.
interface seq_lshift_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;

  modport master (output start, a, b, input  busy, done, s, cout);
  modport slave  (input  start, a, b, output busy, done, s, cout);
endinterface

// File: rtl/seq_lshift_unit.sv
// Multi-cycle logical left shifter: s = a << b, shifting one bit per clock.
// cout holds the last bit that was shifted out of the MSB.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | shifting one position per edge; the counter holds the remaining shifts
// DONE  | one-cycle done pulse; a start here is accepted back-to-back
module seq_lshift_unit #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_lshift_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] LP_MAX_SHIFT = WIDTH[WIDTH-1:0];
  localparam logic [CNT_W-1:0] LP_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_over;
  logic             w_zero;

  // Any amount above WIDTH shifts everything out, so the result is zero.
  assign w_over = (bus.b > LP_MAX_SHIFT);
  assign w_zero = (bus.b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_zero || w_over) ? DONE : SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (r_cnt == LP_CNT_ONE) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= '0;
      r_cout <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_cout <= 1'b0;
      r_s    <= w_over ? '0 : bus.a;
      if (!w_over && !w_zero) r_cnt <= bus.b[CNT_W-1:0];
    end else if (r_state == SHIFT && r_cnt != '0) begin
      r_cout <= r_s[WIDTH-1];
      r_s    <= {r_s[WIDTH-2:0], 1'b0};
      r_cnt  <= r_cnt - LP_CNT_ONE;
    end
  end

  assign bus.busy = (r_state == SHIFT);
  assign bus.done = (r_state == DONE);
  assign bus.s    = r_s;
  assign bus.cout = r_cout;

endmodule
